// File: rtl/mem_arbiter_pkg.sv
// Shared pipeline register package: arbiter state encoding, stage-register
// structs and small sizing helpers used across the MEM stage.
package mem_arbiter_pkg;

   localparam int MAX_WAIT_DEF = 3;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } arb_state_t;

   // Control half of a data-memory access; address and data stay separate
   // because their widths are set per instance.
   typedef struct packed {
      logic       rd;
      logic       wr;
      logic [2:0] func3;
   } mem_ctrl_t;

   typedef struct packed {
      logic       vld;
      logic       we;
      logic [2:0] func3;
   } dbg_ctrl_t;

   // A zero MAX_WAIT still needs a one-bit counter to hold the WAIT entry value.
   function automatic int wcnt_width(input int max_wait);
      return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
   endfunction

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer: y = sel ? b : a.
module mux2 #(
   parameter int W = 1
) (
   input  logic         sel,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/mem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage and a debug/loader port.
// The pipeline normally wins; debug is forced through after MAX_WAIT denials.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DM_ADDRESS  = 9,
   parameter int DATA_W      = 32,
   parameter int MAX_WAIT    = MAX_WAIT_DEF,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   p_rd,
   input  logic                   p_wr,
   input  logic [DM_ADDRESS-1:0]  p_addr,
   input  logic [DATA_W-1:0]      p_wdata,
   input  logic [2:0]             p_func3,
   output logic                   p_stall,
   output logic [DATA_W-1:0]      p_rdata,
   input  logic                   d_req,
   input  logic                   d_we,
   input  logic [DM_ADDRESS-1:0]  d_addr,
   input  logic [DATA_W-1:0]      d_wdata,
   input  logic [2:0]             d_func3,
   output logic                   d_gnt,
   output logic                   d_rvalid,
   output logic [DATA_W-1:0]      d_rdata,
   output logic                   m_rd,
   output logic                   m_wr,
   output logic [DM_ADDRESS-1:0]  m_addr,
   output logic [DATA_W-1:0]      m_wdata,
   output logic [2:0]             m_func3,
   input  logic [DATA_W-1:0]      m_rdata,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam int                WCNT_W   = wcnt_width(MAX_WAIT);
   localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WAIT);
   localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      return (&v) ? v : v + STALL_CNT_W'(1);
   endfunction

   arb_state_t               state_p0;
   logic [WCNT_W-1:0]        wcnt_p0;
   logic                     vld_p1;
   logic [DATA_W-1:0]        rdata_p1;
   logic [STALL_CNT_W-1:0]   stall_cnt_p1;

   logic                     p_act;
   logic                     gnt_dbg;
   logic                     dbg_rd_gnt;
   mem_ctrl_t                p_ctrl;
   mem_ctrl_t                d_ctrl;
   mem_ctrl_t                m_ctrl;

   always_comb begin
      p_act   = p_rd | p_wr;
      gnt_dbg = 1'b0;
      case (state_p0)
         IDLE:    gnt_dbg = d_req & ~p_act;
         WAIT:    gnt_dbg = d_req & (~p_act | (wcnt_p0 >= WCNT_MAX));
         default: gnt_dbg = 1'b0;
      endcase
   end

   assign d_gnt      = gnt_dbg;
   assign p_stall    = p_act & gnt_dbg;
   assign dbg_rd_gnt = gnt_dbg & ~d_we;

   // ---- stage p0: arbitration state ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_p0 <= IDLE;
         wcnt_p0  <= '0;
      end else begin
         case (state_p0)
            IDLE: begin
               if (d_req && p_act) begin
                  state_p0 <= WAIT;
                  wcnt_p0  <= WCNT_ONE;
               end
            end
            WAIT: begin
               // A forced grant restarts the count so the pipeline regains
               // priority for the next MAX_WAIT contested cycles.
               if (gnt_dbg || !d_req) begin
                  state_p0 <= IDLE;
                  wcnt_p0  <= '0;
               end else begin
                  wcnt_p0  <= wcnt_p0 + WCNT_ONE;
               end
            end
            default: begin
               state_p0 <= IDLE;
               wcnt_p0  <= '0;
            end
         endcase
      end
   end

   assign p_ctrl = '{rd: p_rd,  wr: p_wr, func3: p_func3};
   assign d_ctrl = '{rd: ~d_we, wr: d_we, func3: d_func3};

   mux2 #(.W($bits(mem_ctrl_t))) u_ctrl_mux (
      .sel (gnt_dbg),
      .a   (p_ctrl),
      .b   (d_ctrl),
      .y   (m_ctrl)
   );

   mux2 #(.W(DM_ADDRESS)) u_addr_mux (
      .sel (gnt_dbg),
      .a   (p_addr),
      .b   (d_addr),
      .y   (m_addr)
   );

   mux2 #(.W(DATA_W)) u_wdata_mux (
      .sel (gnt_dbg),
      .a   (p_wdata),
      .b   (d_wdata),
      .y   (m_wdata)
   );

   assign m_rd    = m_ctrl.rd;
   assign m_wr    = m_ctrl.wr;
   assign m_func3 = m_ctrl.func3;
   assign p_rdata = m_rdata;

   // ---- stage p1: debug read return and stall statistics ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p1       <= 1'b0;
         rdata_p1     <= '0;
         stall_cnt_p1 <= '0;
      end else begin
         vld_p1 <= dbg_rd_gnt;
         if (dbg_rd_gnt) begin
            rdata_p1 <= m_rdata;
         end
         if (p_stall) begin
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
         end
      end
   end

   assign d_rvalid  = vld_p1;
   assign d_rdata   = rdata_p1;
   assign stall_cnt = stall_cnt_p1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a word-wide memory model behind the arbiter,
// plus a narrow-counter instance sharing the same stimulus for saturation.
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        p_rd, p_wr;
   logic [8:0]  p_addr;
   logic [31:0] p_wdata;
   logic [2:0]  p_func3;
   logic        p_stall;
   logic [31:0] p_rdata;
   logic        d_req, d_we;
   logic [8:0]  d_addr;
   logic [31:0] d_wdata;
   logic [2:0]  d_func3;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        m_rd, m_wr;
   logic [8:0]  m_addr;
   logic [31:0] m_wdata;
   logic [2:0]  m_func3;
   logic [31:0] m_rdata;
   logic [15:0] stall_cnt;

   logic        n_p_stall, n_d_gnt, n_d_rvalid, n_m_rd, n_m_wr;
   logic [31:0] n_p_rdata, n_d_rdata, n_m_wdata;
   logic [8:0]  n_m_addr;
   logic [2:0]  n_m_func3;
   logic [3:0]  n_stall_cnt;

   logic [31:0] mem [0:127];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   assign m_rdata = mem[m_addr[8:2]];
   always @(posedge clk) if (m_wr) mem[m_addr[8:2]] <= m_wdata;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata), .p_func3(p_func3),
      .p_stall(p_stall), .p_rdata(p_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_func3(d_func3),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_func3(m_func3),
      .m_rdata(m_rdata), .stall_cnt(stall_cnt)
   );

   mem_arbiter #(.STALL_CNT_W(4)) dut4 (
      .clk(clk), .reset(reset),
      .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata), .p_func3(p_func3),
      .p_stall(n_p_stall), .p_rdata(n_p_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_func3(d_func3),
      .d_gnt(n_d_gnt), .d_rvalid(n_d_rvalid), .d_rdata(n_d_rdata),
      .m_rd(n_m_rd), .m_wr(n_m_wr), .m_addr(n_m_addr), .m_wdata(n_m_wdata), .m_func3(n_m_func3),
      .m_rdata(m_rdata), .stall_cnt(n_stall_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      p_rd = 0; p_wr = 0; p_addr = '0; p_wdata = '0; p_func3 = 3'd2;
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_func3 = 3'd2;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 0;
      tick(); tick();
      @(negedge clk);
      n_tests++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got %b want 0", d_rvalid); end
      n_tests++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", d_rdata); end
      n_tests++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
      n_tests++; if ({m_rd, m_wr, d_gnt, p_stall} !== 4'b0000) begin n_fail++; $display("FAIL rst_idle_outs got %b want 0000", {m_rd, m_wr, d_gnt, p_stall}); end
      // combinational grant still follows inputs while reset is held
      d_req = 1; d_addr = 9'h10;
      #1;
      n_tests++; if ({d_gnt, m_rd} !== 2'b11) begin n_fail++; $display("FAIL rst_comb_gnt got %b want 11", {d_gnt, m_rd}); end
      tick();
      n_tests++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid_held got %b want 0", d_rvalid); end
      idle_inputs();
      reset = 1;
      tick();
   endtask

   task automatic test_pipe_only();
      p_wr = 1; p_addr = 9'h10; p_wdata = 32'hDEADBEEF;
      @(negedge clk);
      n_tests++; if ({m_wr, m_rd, m_addr, m_wdata} !== {2'b10, 9'h10, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL pipe_wr_mux got wr=%b rd=%b a=%h d=%h want 1 0 010 deadbeef", m_wr, m_rd, m_addr, m_wdata);
      end
      tick();
      p_wr = 0; p_rd = 1;
      @(negedge clk);
      n_tests++; if (p_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pipe_rd got %h want deadbeef", p_rdata); end
      n_tests++; if ({m_rd, p_stall} !== 2'b10) begin n_fail++; $display("FAIL pipe_rd_ctrl got %b want 10", {m_rd, p_stall}); end
      tick();
      p_rd = 0;
      @(negedge clk);
      n_tests++; if ({m_rd, m_wr} !== 2'b00) begin n_fail++; $display("FAIL pipe_idle got %b want 00", {m_rd, m_wr}); end
      n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL pipe_stall_cnt got %0d want 0", stall_cnt); end
      tick();
   endtask

   task automatic test_debug_idle();
      d_req = 1; d_we = 0; d_addr = 9'h10;
      @(negedge clk);
      n_tests++; if ({d_gnt, m_rd, m_wr, m_addr} !== {3'b110, 9'h10}) begin
         n_fail++; $display("FAIL dbg_rd_gnt got gnt=%b rd=%b wr=%b a=%h want 1 1 0 010", d_gnt, m_rd, m_wr, m_addr);
      end
      tick();
      d_req = 0;
      n_tests++; if ({d_rvalid, d_rdata} !== {1'b1, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL dbg_rd_data got v=%b d=%h want 1 deadbeef", d_rvalid, d_rdata);
      end
      tick();
      n_tests++; if ({d_rvalid, d_rdata} !== {1'b0, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL dbg_rd_hold got v=%b d=%h want 0 deadbeef", d_rvalid, d_rdata);
      end
      d_req = 1; d_we = 1; d_addr = 9'h20; d_wdata = 32'h12345678;
      @(negedge clk);
      n_tests++; if ({d_gnt, m_wr, m_rd, m_wdata} !== {3'b110, 32'h12345678}) begin
         n_fail++; $display("FAIL dbg_wr_mux got gnt=%b wr=%b rd=%b d=%h want 1 1 0 12345678", d_gnt, m_wr, m_rd, m_wdata);
      end
      tick();
      d_req = 0; d_we = 0;
      p_rd = 1; p_addr = 9'h20;
      n_tests++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL dbg_wr_no_rvalid got %b want 0", d_rvalid); end
      @(negedge clk);
      n_tests++; if (p_rdata !== 32'h12345678) begin n_fail++; $display("FAIL dbg_wr_readback got %h want 12345678", p_rdata); end
      tick();
      p_rd = 0;
   endtask

   task automatic test_back_to_back();
      d_req = 1; d_we = 0; d_addr = 9'h10;
      tick();
      d_addr = 9'h20;
      n_tests++; if ({d_rvalid, d_rdata} !== {1'b1, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL b2b_first got v=%b d=%h want 1 deadbeef", d_rvalid, d_rdata);
      end
      tick();
      d_req = 0;
      n_tests++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h12345678}) begin
         n_fail++; $display("FAIL b2b_second got v=%b d=%h want 1 12345678", d_rvalid, d_rdata);
      end
      tick();
   endtask

   task automatic test_contention();
      int grants = 0;
      logic exp_g;
      p_rd = 1; p_addr = 9'h10;
      d_req = 1; d_we = 0; d_addr = 9'h20;
      for (int c = 0; c < 12; c++) begin
         exp_g = ((c % 4) == 3);
         @(negedge clk);
         n_tests++; if ({d_gnt, p_stall} !== {exp_g, exp_g}) begin
            n_fail++; $display("FAIL cont_gnt c=%0d got gnt=%b stall=%b want %b", c, d_gnt, p_stall, exp_g);
         end
         n_tests++; if (m_addr !== (exp_g ? 9'h20 : 9'h10)) begin
            n_fail++; $display("FAIL cont_addr c=%0d got %h want %h", c, m_addr, exp_g ? 9'h20 : 9'h10);
         end
         n_tests++; if (stall_cnt !== 16'(grants)) begin
            n_fail++; $display("FAIL cont_stall_cnt c=%0d got %0d want %0d", c, stall_cnt, grants);
         end
         if (!exp_g) begin
            n_tests++; if (p_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cont_prdata c=%0d got %h want deadbeef", c, p_rdata); end
         end
         tick();
         if (exp_g) grants++;
         n_tests++; if (d_rvalid !== exp_g) begin
            n_fail++; $display("FAIL cont_rvalid c=%0d got %b want %b", c, d_rvalid, exp_g);
         end
      end
      n_tests++; if ({d_rdata, stall_cnt} !== {32'h12345678, 16'd3}) begin
         n_fail++; $display("FAIL cont_final got d=%h cnt=%0d want 12345678 3", d_rdata, stall_cnt);
      end
      // dropping the request mid-wait must restart the count
      for (int c = 0; c < 2; c++) tick();
      d_req = 0;
      tick();
      d_req = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_tests++; if (d_gnt !== (c == 3)) begin
            n_fail++; $display("FAIL cont_drop c=%0d got %b want %b", c, d_gnt, c == 3);
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid_wait();
      p_rd = 1; p_addr = 9'h10;
      d_req = 1; d_we = 0; d_addr = 9'h20;
      tick(); tick();
      reset = 0;
      @(negedge clk);
      n_tests++; if ({d_gnt, stall_cnt} !== {1'b0, 16'd0}) begin
         n_fail++; $display("FAIL rmw_in_reset got gnt=%b cnt=%0d want 0 0", d_gnt, stall_cnt);
      end
      tick();
      reset = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_tests++; if (d_gnt !== (c == 3)) begin
            n_fail++; $display("FAIL rmw_gnt c=%0d got %b want %b", c, d_gnt, c == 3);
         end
         tick();
      end
      n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL rmw_stall_cnt got %0d want 1", stall_cnt); end
      idle_inputs();
      tick();
   endtask

   task automatic test_saturation();
      int grants = 0;
      reset = 0;
      tick();
      reset = 1;
      p_rd = 1; p_addr = 9'h10;
      d_req = 1; d_we = 0; d_addr = 9'h20;
      for (int c = 0; c < 80; c++) begin
         tick();
         if ((c % 4) == 3) begin
            grants++;
            if (grants == 14 || grants == 15 || grants == 16 || grants == 20) begin
               n_tests++; if (n_stall_cnt !== 4'((grants > 15) ? 15 : grants)) begin
                  n_fail++; $display("FAIL sat_cnt4 after %0d stalls got %0d want %0d", grants, n_stall_cnt, (grants > 15) ? 15 : grants);
               end
            end
         end
      end
      n_tests++; if (stall_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_cnt16 got %0d want 20", stall_cnt); end
      idle_inputs();
      tick();
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = '0;
      reset = 0;
      idle_inputs();
      test_reset();
      test_pipe_only();
      test_debug_idle();
      test_back_to_back();
      test_contention();
      test_reset_mid_wait();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: DM_ADDRESS, default 9, data-memory byte-address width; DATA_W, default 32, data width; MAX_WAIT, default 3, maximum denied cycles before debug is forced through; STALL_CNT_W, default 16, width of the stall-cycle counter.
REQ-002 Ports SHALL be, one per line, as name direction width meaning:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- p_rd  in  1  pipeline MEM-stage read request.
- p_wr  in  1  pipeline MEM-stage write request.
- p_addr  in  DM_ADDRESS  pipeline address.
- p_wdata  in  DATA_W  pipeline write data.
- p_func3  in  3  pipeline access size/sign.
- p_stall  out  1  freeze IF/ID/EX/MEM this cycle.
- p_rdata  out  DATA_W  pipeline read data.
- d_req  in  1  debug/loader request.
- d_we  in  1  debug write (1) or read (0).
- d_addr  in  DM_ADDRESS  debug address.
- d_wdata  in  DATA_W  debug write data.
- d_func3  in  3  debug access size.
- d_gnt  out  1  debug access performed this cycle.
- d_rvalid  out  1  debug read data valid.
- d_rdata  out  DATA_W  registered debug read data.
- m_rd, m_wr  out  1 each  memory enables.
- m_addr  out  DM_ADDRESS  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_func3  out  3  memory access size.
- m_rdata  in  DATA_W  combinational memory read data.
- stall_cnt  out  STALL_CNT_W  saturating count of p_stall cycles.

Function
REQ-003 p_act SHALL be p_rd OR p_wr; the memory SHALL perform at most one access per cycle (combinational read, write on clock edge).
REQ-004 The FSM SHALL have two states, IDLE and WAIT, plus a wait counter wcnt of width clog2(MAX_WAIT+1).
REQ-005 In IDLE, gnt_dbg SHALL be d_req AND NOT p_act; if d_req AND p_act, the next state SHALL be WAIT with wcnt=1.
REQ-006 In WAIT, gnt_dbg SHALL be d_req AND (NOT p_act OR wcnt==MAX_WAIT); on a grant or when d_req is low the next state SHALL be IDLE with wcnt=0; otherwise wcnt SHALL increment.
REQ-007 d_gnt SHALL equal gnt_dbg combinationally; requester SHALL hold d_req and its operands stable until d_gnt is sampled high.
REQ-008 p_stall SHALL be p_act AND gnt_dbg; during a stall the pipeline access SHALL NOT reach memory and SHALL be retried next cycle unchanged.
REQ-009 The memory mux SHALL drive the debug operands (m_rd = NOT d_we, m_wr = d_we) when gnt_dbg is high, and the pipeline operands otherwise (including m_rd = m_wr = 0 when idle).
REQ-010 p_rdata SHALL equal m_rdata whenever gnt_dbg is low; its value is don't-care while p_stall is high.
REQ-011 On a granted debug read, d_rdata SHALL capture m_rdata and d_rvalid SHALL be 1 for exactly the next cycle; otherwise d_rvalid SHALL be 0 and d_rdata SHALL hold.
REQ-012 stall_cnt SHALL increment by 1 each p_stall cycle, saturate at all-ones, and never wrap.
REQ-013 Debug latency SHALL be bounded: a continuously asserted d_req SHALL be granted within MAX_WAIT+1 cycles.
REQ-014 Once forced, wcnt SHALL restart, so the pipeline wins the next MAX_WAIT contested cycles.

Reset
REQ-015 While reset is low: state=IDLE, wcnt=0, d_rvalid=0, d_rdata=0, stall_cnt=0; combinational outputs follow REQ-007..010.
REQ-016 Reset asserted mid-WAIT SHALL discard the pending count; no partial access is retained.

Structure
REQ-017 The state enum (IDLE, WAIT) and the MAX_WAIT default SHALL live in the shared pipeline register package alongside the stage-register structs.
REQ-018 The operand multiplexer SHALL reuse the existing mux2 module; no other sub-modules.

Verification
REQ-019 Pipeline-only traffic: p_wr to addr 0x10, data 0xDEADBEEF, then p_rd of 0x10 -> p_rdata=0xDEADBEEF; p_stall=0; stall_cnt=0.
REQ-020 Debug into idle pipeline: d_req, d_we=0, addr 0x10 -> d_gnt same cycle; d_rvalid=1 next cycle with d_rdata=0xDEADBEEF.
REQ-021 Contention, MAX_WAIT=3: p_rd held high, d_req high from cycle 0 -> d_gnt=0 in cycles 0-2, d_gnt=1 and p_stall=1 in cycle 3; stall_cnt=1.
REQ-022 Sustained contention over 12 cycles -> debug granted in cycles 3, 7, 11; pipeline served in all others.
REQ-023 Reset pulse low in cycle 2 of WAIT -> after release, state IDLE, wcnt restarts; grant at cycle 3 after release.
REQ-024 stall_cnt preset to near saturation using STALL_CNT_W=4 -> value holds at 15 after further stalls.
